// File: rtl/axil_arb_2m.sv
// Two-master AXI4-Lite arbiter; round-robin write and read paths to one slave.
// Optional ARB_ADDR_CHECK_EN: decode-error addresses at or above ADDR_LIMIT.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   m0_* / m1_*           AXI4-Lite slave ports facing the two masters
//   s_*                   AXI4-Lite master port facing the register file
//   wr_gnt / rd_gnt       one-hot current write / read grant, 00 = idle
module axil_arb_2m #(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h20
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,

    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,

    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,

    output logic [1:0]          wr_gnt,
    output logic [1:0]          rd_gnt
);

`ifdef ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [1:0] DECERR = 2'b11;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_t;

    w_state_t            w_state;
    logic                wr_ptr;
    logic                aw_done;
    logic                w_done;
    logic                wr_bad;
    logic [1:0]          wr_req;
    logic [1:0]          wr_pick;
    logic [ADDR_W-1:0]   wr_pick_addr;
    logic                wr_sel;
    logic                w_fwd;
    logic                w_resp;
    logic                aw_pend;
    logic                w_pend;
    logic                aw_acc;
    logic                w_acc;
    logic                aw_hs;
    logic                w_hs;
    logic                b_valid;
    logic [1:0]          b_resp;
    logic                sel_bready;
    logic                b_hs;

    assign wr_req = {m1_awvalid, m0_awvalid};

    always_comb begin
        wr_pick = 2'b00;
        unique case (wr_req)
            2'b01:   wr_pick = 2'b01;
            2'b10:   wr_pick = 2'b10;
            2'b11:   wr_pick = wr_ptr ? 2'b10 : 2'b01;
            default: wr_pick = 2'b00;
        endcase
    end

    assign wr_pick_addr = wr_pick[1] ? m1_awaddr : m0_awaddr;

    assign wr_sel = wr_gnt[1];
    assign w_fwd  = (w_state == W_FWD);
    assign w_resp = (w_state == W_RESP);

    assign aw_pend = w_fwd & ~aw_done & (wr_sel ? m1_awvalid : m0_awvalid);
    assign w_pend  = w_fwd & ~w_done & (wr_sel ? m1_wvalid : m0_wvalid);

    // A decode-error transaction is absorbed here instead of the slave.
    assign aw_acc = wr_bad | s_awready;
    assign w_acc  = wr_bad | s_wready;
    assign aw_hs  = aw_pend & aw_acc;
    assign w_hs   = w_pend & w_acc;

    assign s_awvalid = aw_pend & ~wr_bad;
    assign s_wvalid  = w_pend & ~wr_bad;
    assign s_awaddr  = w_fwd ? (wr_sel ? m1_awaddr : m0_awaddr) : '0;
    assign s_wdata   = w_fwd ? (wr_sel ? m1_wdata : m0_wdata) : '0;
    assign s_wstrb   = w_fwd ? (wr_sel ? m1_wstrb : m0_wstrb) : '0;

    assign m0_awready = wr_gnt[0] & w_fwd & ~aw_done & aw_acc;
    assign m1_awready = wr_gnt[1] & w_fwd & ~aw_done & aw_acc;
    assign m0_wready  = wr_gnt[0] & w_fwd & ~w_done & w_acc;
    assign m1_wready  = wr_gnt[1] & w_fwd & ~w_done & w_acc;

    assign sel_bready = wr_sel ? m1_bready : m0_bready;
    assign b_valid    = w_resp & (wr_bad | s_bvalid);
    assign b_resp     = wr_bad ? DECERR : s_bresp;
    assign b_hs       = b_valid & sel_bready;
    assign s_bready   = w_resp & ~wr_bad & sel_bready;

    assign m0_bvalid = wr_gnt[0] & b_valid;
    assign m1_bvalid = wr_gnt[1] & b_valid;
    assign m0_bresp  = wr_gnt[0] ? b_resp : 2'b00;
    assign m1_bresp  = wr_gnt[1] ? b_resp : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            wr_gnt  <= 2'b00;
            wr_ptr  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wr_bad  <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (|wr_req) begin
                        wr_gnt  <= wr_pick;
                        wr_bad  <= ADDR_CHECK &&
                                   (wr_pick_addr >= ADDR_LIMIT);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        w_state <= W_FWD;
                    end
                end
                W_FWD: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) && (w_done | w_hs))
                        w_state <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state <= W_IDLE;
                        wr_gnt  <= 2'b00;
                        wr_ptr  <= ~wr_sel;
                        wr_bad  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA} r_state_t;

    r_state_t            r_state;
    logic                rd_ptr;
    logic                rd_bad;
    logic [1:0]          rd_req;
    logic [1:0]          rd_pick;
    logic [ADDR_W-1:0]   rd_pick_addr;
    logic                rd_sel;
    logic                r_fwd;
    logic                r_dat;
    logic                ar_pend;
    logic                ar_acc;
    logic                ar_hs;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                sel_rready;
    logic                r_hs;

    assign rd_req = {m1_arvalid, m0_arvalid};

    always_comb begin
        rd_pick = 2'b00;
        unique case (rd_req)
            2'b01:   rd_pick = 2'b01;
            2'b10:   rd_pick = 2'b10;
            2'b11:   rd_pick = rd_ptr ? 2'b10 : 2'b01;
            default: rd_pick = 2'b00;
        endcase
    end

    assign rd_pick_addr = rd_pick[1] ? m1_araddr : m0_araddr;

    assign rd_sel = rd_gnt[1];
    assign r_fwd  = (r_state == R_FWD);
    assign r_dat  = (r_state == R_DATA);

    assign ar_pend = r_fwd & (rd_sel ? m1_arvalid : m0_arvalid);
    assign ar_acc  = rd_bad | s_arready;
    assign ar_hs   = ar_pend & ar_acc;

    assign s_arvalid = ar_pend & ~rd_bad;
    assign s_araddr  = r_fwd ? (rd_sel ? m1_araddr : m0_araddr) : '0;

    assign m0_arready = rd_gnt[0] & r_fwd & ar_acc;
    assign m1_arready = rd_gnt[1] & r_fwd & ar_acc;

    assign sel_rready = rd_sel ? m1_rready : m0_rready;
    assign r_valid    = r_dat & (rd_bad | s_rvalid);
    assign r_data     = rd_bad ? '0 : s_rdata;
    assign r_resp     = rd_bad ? DECERR : s_rresp;
    assign r_hs       = r_valid & sel_rready;
    assign s_rready   = r_dat & ~rd_bad & sel_rready;

    assign m0_rvalid = rd_gnt[0] & r_valid;
    assign m1_rvalid = rd_gnt[1] & r_valid;
    assign m0_rdata  = rd_gnt[0] ? r_data : '0;
    assign m1_rdata  = rd_gnt[1] ? r_data : '0;
    assign m0_rresp  = rd_gnt[0] ? r_resp : 2'b00;
    assign m1_rresp  = rd_gnt[1] ? r_resp : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rd_gnt  <= 2'b00;
            rd_ptr  <= 1'b0;
            rd_bad  <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (|rd_req) begin
                        rd_gnt  <= rd_pick;
                        rd_bad  <= ADDR_CHECK &&
                                   (rd_pick_addr >= ADDR_LIMIT);
                        r_state <= R_FWD;
                    end
                end
                R_FWD: begin
                    if (ar_hs)
                        r_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_state <= R_IDLE;
                        rd_gnt  <= 2'b00;
                        rd_ptr  <= ~rd_sel;
                        rd_bad  <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_arb_2m.sv
// Directed testbench for axil_arb_2m with an 8 x 32-bit register-file slave.
// Checks grants, routing, fairness, backpressure, concurrency and reset.
module tb_axil_arb_2m;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] awaddr[2], wdata[2], araddr[2], rdata[2];
    logic [3:0]  wstrb[2];
    logic        awvalid[2], awready[2], wvalid[2], wready[2];
    logic        bvalid[2], bready[2], arvalid[2], arready[2];
    logic        rvalid[2], rready[2];
    logic [1:0]  bresp[2], rresp[2];

    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [1:0]  wr_gnt, rd_gnt;

    int checks = 0;
    int errors = 0;

    axil_arb_2m dut (
        .clk(clk), .rst_n(rst_n),
        .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
        .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]),
        .m0_wready(wready[0]), .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]),
        .m0_bready(bready[0]), .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]),
        .m0_arready(arready[0]), .m0_rdata(rdata[0]), .m0_rresp(rresp[0]),
        .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
        .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]),
        .m1_wready(wready[1]), .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]),
        .m1_bready(bready[1]), .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]),
        .m1_arready(arready[1]), .m1_rdata(rdata[1]), .m1_rresp(rresp[1]),
        .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
    );

    // Register-file slave model.
    logic [31:0] regs[8];
    logic        aw_got, w_got;
    logic [2:0]  aw_idx;
    logic [31:0] w_dat;

    assign s_awready = ~aw_got & ~s_bvalid;
    assign s_wready  = ~w_got & ~s_bvalid;
    assign s_arready = ~s_rvalid;
    assign s_bresp   = 2'b00;
    assign s_rresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            aw_idx   <= '0;
            w_dat    <= '0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_got <= 1'b1;
                aw_idx <= s_awaddr[4:2];
            end
            if (s_wvalid && s_wready) begin
                w_got <= 1'b1;
                w_dat <= s_wdata;
            end
            if (aw_got && w_got && !s_bvalid) begin
                regs[aw_idx] <= w_dat;
                s_bvalid     <= 1'b1;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end
            if (s_bvalid && s_bready)
                s_bvalid <= 1'b0;
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= regs[s_araddr[4:2]];
            end
            if (s_rvalid && s_rready)
                s_rvalid <= 1'b0;
        end
    end

    // Grant-sequence and routing monitors.
    logic [1:0]  wq[$];
    logic [1:0]  rq[$];
    logic [1:0]  wr_prev = 2'b00;
    logic [1:0]  rd_prev = 2'b00;
    logic [31:0] last_awaddr = '0;
    bit          overlap = 0;
    bit          leak = 0;
    bit          ar_seen = 0;
    bit          aw_seen = 0;

    always @(negedge clk) begin
        if (wr_gnt != 2'b00 && wr_prev == 2'b00) wq.push_back(wr_gnt);
        if (rd_gnt != 2'b00 && rd_prev == 2'b00) rq.push_back(rd_gnt);
        wr_prev <= wr_gnt;
        rd_prev <= rd_gnt;
        if (wr_gnt == 2'b01 && rd_gnt == 2'b10) overlap <= 1;
        if (rd_gnt == 2'b10 && rdata[0] != 32'h0) leak <= 1;
        if (s_arvalid) ar_seen <= 1;
        if (s_awvalid) aw_seen <= 1;
    end

    always @(posedge clk)
        if (s_awvalid && s_awready) last_awaddr <= s_awaddr;

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awvalid[i] = 0; wdata[i] = '0; wstrb[i] = '0;
            wvalid[i] = 0; bready[i] = 0; araddr[i] = '0; arvalid[i] = 0;
            rready[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wq.delete();
        rq.delete();
    endtask

    task automatic do_write(input int m, input logic [31:0] a,
                            input logic [31:0] d, input int bhold,
                            output logic [1:0] r, output bit ok);
        int n = 0;
        int h = bhold;
        bit awd = 0, wd = 0, got = 0;
        r = 2'b00;
        awaddr[m] = a; wdata[m] = d; wstrb[m] = 4'hF;
        awvalid[m] = 1; wvalid[m] = 1; bready[m] = (h == 0);
        while (!(awd && wd) && n < 60) begin
            @(negedge clk);
            if (awvalid[m] && awready[m]) awd = 1;
            if (wvalid[m] && wready[m]) wd = 1;
            @(posedge clk); #1;
            if (awd) awvalid[m] = 0;
            if (wd) wvalid[m] = 0;
            n++;
        end
        awvalid[m] = 0;
        wvalid[m] = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (bvalid[m]) begin
                if (bready[m]) begin
                    got = 1;
                    r = bresp[m];
                end else if (h > 0) h--;
            end
            @(posedge clk); #1;
            if (h == 0) bready[m] = 1;
            n++;
        end
        bready[m] = 0;
        ok = got;
    endtask

    task automatic do_read(input int m, input logic [31:0] a,
                           output logic [31:0] d, output logic [1:0] r,
                           output bit ok);
        int n = 0;
        bit ard = 0, got = 0;
        d = '0; r = 2'b00;
        araddr[m] = a; arvalid[m] = 1; rready[m] = 1;
        while (!ard && n < 40) begin
            @(negedge clk);
            if (arready[m]) ard = 1;
            @(posedge clk); #1;
            n++;
        end
        arvalid[m] = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (rvalid[m]) begin
                got = 1;
                d = rdata[m];
                r = rresp[m];
            end
            @(posedge clk); #1;
            n++;
        end
        rready[m] = 0;
        ok = got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_gnt, rd_gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt got %b/%b want 00/00", wr_gnt, rd_gnt);
        end
        checks++;
        if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_s_valid got %b want 00000",
                     {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready});
        end
        checks++;
        if ({s_awaddr, s_wdata, s_araddr} !== 96'h0 ||
            {awready[0], wready[1], bvalid[0], arready[1], rvalid[0]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %h want 0", s_awaddr,
                     s_wdata, s_araddr);
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        logic [1:0] r; logic [31:0] d; bit ok;
        apply_reset();
        fork
            do_write(0, 32'h04, 32'hDEADBEEF, 0, r, ok);
            begin
                @(negedge clk);
                checks++;
                if (wr_gnt !== 2'b00 || s_awvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_c0 got gnt %b awv %b want 00 0",
                             wr_gnt, s_awvalid);
                end
                @(negedge clk);
                checks++;
                if (wr_gnt !== 2'b01 || s_awvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_c1 got gnt %b awv %b want 01 1",
                             wr_gnt, s_awvalid);
                end
            end
        join
        checks++;
        if (!ok || r !== 2'b00 || last_awaddr !== 32'h04) begin
            errors++;
            $display("FAIL wr_m0 got ok %0d bresp %b addr %h want 1 00 04",
                     ok, r, last_awaddr);
        end
        do_read(0, 32'h04, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
            errors++;
            $display("FAIL rd_m0 got %h/%b want deadbeef/00", d, r);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] r0, r1; logic [31:0] d; bit ok0, ok1;
        apply_reset();
        fork
            do_write(0, 32'h00, 32'h11, 0, r0, ok0);
            do_write(1, 32'h08, 32'h22, 0, r1, ok1);
        join
        checks++;
        if (wq.size() != 2 || wq[0] !== 2'b01 || wq[1] !== 2'b10) begin
            errors++;
            $display("FAIL simul_order got n=%0d %b %b want 01 10",
                     wq.size(), wq[0], wq[1]);
        end
        checks++;
        if (!ok0 || !ok1 || r0 !== 2'b00 || r1 !== 2'b00) begin
            errors++;
            $display("FAIL simul_bresp got %b %b want 00 00", r0, r1);
        end
        do_read(0, 32'h00, d, r0, ok0);
        checks++;
        if (d !== 32'h11) begin
            errors++;
            $display("FAIL simul_rd00 got %h want 00000011", d);
        end
        do_read(0, 32'h08, d, r0, ok0);
        checks++;
        if (d !== 32'h22) begin
            errors++;
            $display("FAIL simul_rd08 got %h want 00000022", d);
        end
    endtask

    task automatic test_back_to_back();
        int bad0 = 0, bad1 = 0;
        apply_reset();
        fork
            for (int i = 0; i < 4; i++) begin
                logic [31:0] d; logic [1:0] r; bit ok;
                do_read(0, 32'h00, d, r, ok);
                if (!ok || d !== 32'h11) bad0++;
            end
            for (int j = 0; j < 4; j++) begin
                logic [31:0] d; logic [1:0] r; bit ok;
                do_read(1, 32'h08, d, r, ok);
                if (!ok || d !== 32'h22) bad1++;
            end
        join
        checks++;
        if (rq.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", rq.size());
        end
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp;
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (rq[k] !== exp) begin
                errors++;
                $display("FAIL b2b_gnt%0d got %b want %b", k, rq[k], exp);
            end
        end
        checks++;
        if (bad0 != 0 || bad1 != 0) begin
            errors++;
            $display("FAIL b2b_data got bad %0d/%0d want 0/0", bad0, bad1);
        end
    endtask

    task automatic test_bready_hold();
        logic [1:0] r0, r1; bit ok0, ok1;
        int hold_bad = 0;
        bit seen = 0;
        apply_reset();
        fork
            do_write(1, 32'h14, 32'h55, 5, r1, ok1);
            begin
                repeat (2) @(posedge clk);
                #1 do_write(0, 32'h18, 32'h66, 0, r0, ok0);
            end
            begin
                for (int n = 0; n < 20 && !seen; n++) begin
                    @(negedge clk);
                    if (bvalid[1]) seen = 1;
                end
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    if (bvalid[1] !== 1'b1 || wr_gnt !== 2'b10 ||
                        awready[0] !== 1'b0)
                        hold_bad++;
                end
            end
        join
        checks++;
        if (!seen || hold_bad != 0) begin
            errors++;
            $display("FAIL bhold_stall got seen %0d bad %0d want 1 0",
                     seen, hold_bad);
        end
        checks++;
        if (wq.size() != 2 || wq[0] !== 2'b10 || wq[1] !== 2'b01) begin
            errors++;
            $display("FAIL bhold_order got n=%0d %b %b want 10 01",
                     wq.size(), wq[0], wq[1]);
        end
        checks++;
        if (!ok0 || !ok1 || r0 !== 2'b00 || r1 !== 2'b00) begin
            errors++;
            $display("FAIL bhold_done got ok %0d%0d want 11", ok0, ok1);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] wr_r, rd_r; logic [31:0] d; bit wok, rok;
        apply_reset();
        do_write(1, 32'h10, 32'hA5A50010, 0, wr_r, wok);
        wq.delete();
        rq.delete();
        overlap = 0;
        leak = 0;
        fork
            do_write(0, 32'h0C, 32'h77, 0, wr_r, wok);
            do_read(1, 32'h10, d, rd_r, rok);
        join
        checks++;
        if (!overlap || wq[0] !== 2'b01 || rq[0] !== 2'b10) begin
            errors++;
            $display("FAIL conc_overlap got %0d %b %b want 1 01 10",
                     overlap, wq[0], rq[0]);
        end
        checks++;
        if (!wok || wr_r !== 2'b00 || !rok || d !== 32'hA5A50010 ||
            rd_r !== 2'b00) begin
            errors++;
            $display("FAIL conc_data got %h/%b want a5a50010/00", d, rd_r);
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL conc_rdata_leak got nonzero m0_rdata want 0");
        end
        do_read(0, 32'h0C, d, rd_r, rok);
        checks++;
        if (d !== 32'h77) begin
            errors++;
            $display("FAIL conc_rb got %h want 00000077", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; bit ok;
        bit awd = 0, wd = 0, seen = 0;
        apply_reset();
        awaddr[0] = 32'h1C; wdata[0] = 32'hBAD; wstrb[0] = 4'hF;
        awvalid[0] = 1; wvalid[0] = 1; bready[0] = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bvalid[0]) seen = 1;
            else begin
                if (awready[0]) awd = 1;
                if (wready[0]) wd = 1;
                @(posedge clk); #1;
                if (awd) awvalid[0] = 0;
                if (wd) wvalid[0] = 0;
            end
        end
        checks++;
        if (!seen || wr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL rmid_resp got bvalid %0d gnt %b want 1 01",
                     seen, wr_gnt);
        end
        awvalid[0] = 0;
        wvalid[0] = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bvalid[0] !== 1'b0 || wr_gnt !== 2'b00 || rd_gnt !== 2'b00 ||
            s_bready !== 1'b0 || s_awvalid !== 1'b0 || s_awaddr !== 32'h0) begin
            errors++;
            $display("FAIL rmid_clear got bv %b gnt %b/%b want 0 00/00",
                     bvalid[0], wr_gnt, rd_gnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wq.delete();
        do_write(1, 32'h1C, 32'h99, 0, r, ok);
        checks++;
        if (!ok || r !== 2'b00 || wq.size() != 1 || wq[0] !== 2'b10) begin
            errors++;
            $display("FAIL rmid_after got ok %0d bresp %b want 1 00", ok, r);
        end
    endtask

`ifdef ARB_ADDR_CHECK_EN
    task automatic test_addr_check();
        logic [1:0] r; logic [31:0] d; bit ok;
        apply_reset();
        ar_seen = 0;
        aw_seen = 0;
        do_read(0, 32'h40, d, r, ok);
        checks++;
        if (!ok || r !== 2'b11 || d !== 32'h0 || ar_seen) begin
            errors++;
            $display("FAIL chk_rd got %h/%b arv %0d want 0/11 0", d, r, ar_seen);
        end
        do_write(1, 32'h40, 32'h1, 0, r, ok);
        checks++;
        if (!ok || r !== 2'b11 || aw_seen) begin
            errors++;
            $display("FAIL chk_wr got %b awv %0d want 11 0", r, aw_seen);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awvalid[i] = 0; wdata[i] = '0; wstrb[i] = '0;
            wvalid[i] = 0; bready[i] = 0; araddr[i] = '0; arvalid[i] = 0;
            rready[i] = 0;
        end
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_bready_hold();
        test_concurrent();
        test_reset_mid();
`ifdef ARB_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
